// File: rtl/hit_window_judge.sv
// -----------------------------------------------------------------------------
// hit_window_judge
//
// Timing judge between the debounced player keys and the score tracker.
// Every spawned arrow is timestamped with its arrival tick and pushed into a
// per-lane FIFO (8 lanes: [3:0] player A, [7:4] player B; up, down, right,
// left). A rising key edge is graded against the head of its lane as perfect
// or good. A press that falls outside the good window is ignored. An arrow
// whose arrival lies more than GOOD_WIN ticks in the past retires as a miss.
//
// Ports
//   CLOCK_50        system clock
//   resetn          asynchronous active-low reset
//   game_active     1 = running, 0 = frozen (queues and tick preserved)
//   clear           synchronous flush of queues, tick, overflow and outputs
//   pattern_valid   one-cycle spawn strobe qualifying pattern_out
//   pattern_out     spawn lanes
//   player_a_keys   debounced level keys, player A
//   player_b_keys   debounced level keys, player B
//   *_hit_*, miss_* one-cycle pulses, high when the matching count is non-zero
//   *_cnt_*         judgments of that kind in the judged cycle (0..4)
//   overflow        sticky, a spawn was dropped on a full lane
// -----------------------------------------------------------------------------
module hit_window_judge #(
  parameter int TICK_DIV     = 50000,
  parameter int TRAVEL_TICKS = 2000,
  parameter int PERFECT_WIN  = 50,
  parameter int GOOD_WIN     = 150,
  parameter int DEPTH        = 4
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       game_active,
  input  logic       clear,
  input  logic       pattern_valid,
  input  logic [7:0] pattern_out,
  input  logic [3:0] player_a_keys,
  input  logic [3:0] player_b_keys,
  output logic       perfect_hit_a,
  output logic       perfect_hit_b,
  output logic       good_hit_a,
  output logic       good_hit_b,
  output logic       miss_a,
  output logic       miss_b,
  output logic [2:0] perfect_cnt_a,
  output logic [2:0] perfect_cnt_b,
  output logic [2:0] good_cnt_a,
  output logic [2:0] good_cnt_b,
  output logic [2:0] miss_cnt_a,
  output logic [2:0] miss_cnt_b,
  output logic       overflow
);

  localparam int LANES = 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int PSW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PSW-1:0]     PS_LAST = PSW'(TICK_DIV - 1);
  localparam logic [15:0]        TRAVEL  = 16'(TRAVEL_TICKS);
  localparam logic [15:0]        PERF_W  = 16'(PERFECT_WIN);
  localparam logic [15:0]        GOOD_W  = 16'(GOOD_WIN);
  localparam logic signed [15:0] GOOD_S  = 16'(GOOD_WIN);
  localparam logic [AW:0]        FULL    = (AW + 1)'(DEPTH);

  // tick base
  logic [PSW-1:0] r_presc;
  logic [15:0]    r_now;
  logic [7:0]     r_key_q;

  // per-lane FIFOs of arrival ticks
  logic [15:0]    r_mem    [LANES][DEPTH];
  logic [AW-1:0]  r_rd_ptr [LANES];
  logic [AW-1:0]  r_wr_ptr [LANES];
  logic [AW:0]    r_cnt    [LANES];

  logic           r_overflow;
  logic [2:0]     r_perf_cnt_a, r_perf_cnt_b;
  logic [2:0]     r_good_cnt_a, r_good_cnt_b;
  logic [2:0]     r_miss_cnt_a, r_miss_cnt_b;

  logic [7:0]        w_keys;
  logic [7:0]        w_edge;
  logic [7:0]        w_nonempty;
  logic [7:0]        w_perf;
  logic [7:0]        w_good;
  logic [7:0]        w_expire;
  logic [7:0]        w_pop;
  logic [7:0]        w_push_req;
  logic [7:0]        w_push;
  logic              w_drop;
  logic [15:0]       w_head [LANES];
  logic signed [15:0] w_dist [LANES];
  logic [15:0]       w_abs  [LANES];
  logic [2:0]        w_perf_cnt_a, w_perf_cnt_b;
  logic [2:0]        w_good_cnt_a, w_good_cnt_b;
  logic [2:0]        w_miss_cnt_a, w_miss_cnt_b;

  assign w_keys = {player_b_keys, player_a_keys};
  assign w_edge = w_keys & ~r_key_q;

  always_comb begin
    w_nonempty = '0;
    w_perf     = '0;
    w_good     = '0;
    w_expire   = '0;
    w_pop      = '0;
    w_push_req = '0;
    w_push     = '0;
    w_drop     = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      w_head[l] = r_mem[l][r_rd_ptr[l]];
      // signed wrap-around distance: negative means the press is early
      w_dist[l] = r_now - w_head[l];
      w_abs[l]  = w_dist[l][15] ? (~w_dist[l] + 16'd1) : w_dist[l];

      w_nonempty[l] = (r_cnt[l] != '0);
      w_perf[l]   = game_active & w_edge[l] & w_nonempty[l] & (w_abs[l] <= PERF_W);
      w_good[l]   = game_active & w_edge[l] & w_nonempty[l] &
                    (w_abs[l] > PERF_W) & (w_abs[l] <= GOOD_W);
      // d > GOOD_WIN implies |d| > GOOD_WIN, so expiry never coincides with a hit
      w_expire[l] = game_active & w_nonempty[l] & (w_dist[l] > GOOD_S);
      w_pop[l]    = w_perf[l] | w_good[l] | w_expire[l];

      // a full lane still accepts a push when its head leaves in the same cycle
      w_push_req[l] = game_active & pattern_valid & pattern_out[l];
      w_push[l]     = w_push_req[l] & ((r_cnt[l] != FULL) | w_pop[l]);
      w_drop        = w_drop | (w_push_req[l] & ~w_push[l]);
    end
  end

  always_comb begin
    w_perf_cnt_a = '0;
    w_perf_cnt_b = '0;
    w_good_cnt_a = '0;
    w_good_cnt_b = '0;
    w_miss_cnt_a = '0;
    w_miss_cnt_b = '0;
    for (int l = 0; l < 4; l++) begin
      w_perf_cnt_a = w_perf_cnt_a + 3'(w_perf[l]);
      w_perf_cnt_b = w_perf_cnt_b + 3'(w_perf[l+4]);
      w_good_cnt_a = w_good_cnt_a + 3'(w_good[l]);
      w_good_cnt_b = w_good_cnt_b + 3'(w_good[l+4]);
      w_miss_cnt_a = w_miss_cnt_a + 3'(w_expire[l]);
      w_miss_cnt_b = w_miss_cnt_b + 3'(w_expire[l+4]);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_presc      <= '0;
      r_now        <= '0;
      r_key_q      <= '0;
      r_overflow   <= 1'b0;
      r_perf_cnt_a <= '0;
      r_perf_cnt_b <= '0;
      r_good_cnt_a <= '0;
      r_good_cnt_b <= '0;
      r_miss_cnt_a <= '0;
      r_miss_cnt_b <= '0;
      for (int l = 0; l < LANES; l++) begin
        r_rd_ptr[l] <= '0;
        r_wr_ptr[l] <= '0;
        r_cnt[l]    <= '0;
      end
    end else begin
      // key history follows the keys even while paused, so a key held
      // across a pause cannot fire on resume
      r_key_q <= w_keys;
      if (clear) begin
        r_presc      <= '0;
        r_now        <= '0;
        r_overflow   <= 1'b0;
        r_perf_cnt_a <= '0;
        r_perf_cnt_b <= '0;
        r_good_cnt_a <= '0;
        r_good_cnt_b <= '0;
        r_miss_cnt_a <= '0;
        r_miss_cnt_b <= '0;
        for (int l = 0; l < LANES; l++) begin
          r_rd_ptr[l] <= '0;
          r_wr_ptr[l] <= '0;
          r_cnt[l]    <= '0;
        end
      end else begin
        if (game_active) begin
          if (r_presc == PS_LAST) begin
            r_presc <= '0;
            r_now   <= r_now + 16'd1;
          end else begin
            r_presc <= r_presc + 1'b1;
          end
        end
        for (int l = 0; l < LANES; l++) begin
          if (w_push[l]) r_wr_ptr[l] <= r_wr_ptr[l] + 1'b1;
          if (w_pop[l])  r_rd_ptr[l] <= r_rd_ptr[l] + 1'b1;
          if (w_push[l] && !w_pop[l])
            r_cnt[l] <= r_cnt[l] + 1'b1;
          else if (!w_push[l] && w_pop[l])
            r_cnt[l] <= r_cnt[l] - 1'b1;
        end
        if (w_drop) r_overflow <= 1'b1;
        r_perf_cnt_a <= w_perf_cnt_a;
        r_perf_cnt_b <= w_perf_cnt_b;
        r_good_cnt_a <= w_good_cnt_a;
        r_good_cnt_b <= w_good_cnt_b;
        r_miss_cnt_a <= w_miss_cnt_a;
        r_miss_cnt_b <= w_miss_cnt_b;
      end
    end
  end

  // storage carries no reset; occupancy and pointers define what is valid
  always_ff @(posedge CLOCK_50) begin
    for (int l = 0; l < LANES; l++) begin
      if (w_push[l]) r_mem[l][r_wr_ptr[l]] <= r_now + TRAVEL;
    end
  end

  assign perfect_cnt_a = r_perf_cnt_a;
  assign perfect_cnt_b = r_perf_cnt_b;
  assign good_cnt_a    = r_good_cnt_a;
  assign good_cnt_b    = r_good_cnt_b;
  assign miss_cnt_a    = r_miss_cnt_a;
  assign miss_cnt_b    = r_miss_cnt_b;
  assign perfect_hit_a = |r_perf_cnt_a;
  assign perfect_hit_b = |r_perf_cnt_b;
  assign good_hit_a    = |r_good_cnt_a;
  assign good_hit_b    = |r_good_cnt_b;
  assign miss_a        = |r_miss_cnt_a;
  assign miss_b        = |r_miss_cnt_b;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_hit_window_judge.sv
module tb_hit_window_judge;

  logic       CLOCK_50 = 1'b0;
  logic       resetn;
  logic       game_active;
  logic       clear;
  logic       pattern_valid;
  logic [7:0] pattern_out;
  logic [3:0] player_a_keys;
  logic [3:0] player_b_keys;
  logic       perfect_hit_a, perfect_hit_b, good_hit_a, good_hit_b, miss_a, miss_b;
  logic [2:0] perfect_cnt_a, perfect_cnt_b, good_cnt_a, good_cnt_b, miss_cnt_a, miss_cnt_b;
  logic       overflow;

  always #5 CLOCK_50 = ~CLOCK_50;

  hit_window_judge #(
    .TICK_DIV(4), .TRAVEL_TICKS(100), .PERFECT_WIN(5), .GOOD_WIN(15), .DEPTH(4)
  ) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .game_active(game_active), .clear(clear),
    .pattern_valid(pattern_valid), .pattern_out(pattern_out),
    .player_a_keys(player_a_keys), .player_b_keys(player_b_keys),
    .perfect_hit_a(perfect_hit_a), .perfect_hit_b(perfect_hit_b),
    .good_hit_a(good_hit_a), .good_hit_b(good_hit_b),
    .miss_a(miss_a), .miss_b(miss_b),
    .perfect_cnt_a(perfect_cnt_a), .perfect_cnt_b(perfect_cnt_b),
    .good_cnt_a(good_cnt_a), .good_cnt_b(good_cnt_b),
    .miss_cnt_a(miss_cnt_a), .miss_cnt_b(miss_cnt_b),
    .overflow(overflow)
  );

  int n_checks = 0;
  int n_errors = 0;
  // bench-side tick model: prescaler and `now`
  int m_now   = 0;
  int m_presc = 0;
  // accumulated observations
  int sum_miss_a = 0;
  int sum_miss_b = 0;
  int sum_act    = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // sum of every pulse and count output, overflow excluded
  function automatic int act_now();
    return int'(perfect_hit_a) + int'(perfect_hit_b) + int'(good_hit_a) + int'(good_hit_b) +
           int'(miss_a) + int'(miss_b) + int'(perfect_cnt_a) + int'(perfect_cnt_b) +
           int'(good_cnt_a) + int'(good_cnt_b) + int'(miss_cnt_a) + int'(miss_cnt_b);
  endfunction

  task automatic tick();
    @(posedge CLOCK_50);
    if (!resetn || clear) begin
      m_now   = 0;
      m_presc = 0;
    end else if (game_active) begin
      if (m_presc == 3) begin
        m_presc = 0;
        m_now   = m_now + 1;
      end else begin
        m_presc = m_presc + 1;
      end
    end
    #1;
    sum_miss_a += int'(miss_cnt_a);
    sum_miss_b += int'(miss_cnt_b);
    sum_act    += act_now();
  endtask

  // advance until just after the edge where `now` became n
  task automatic run_to(input int n);
    int guard = 0;
    while (!(m_now == n && m_presc == 0) && guard < 3000) begin
      tick();
      guard++;
    end
    if (guard >= 3000) chk("run_to_timeout", m_now, n);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic spawn(input logic [7:0] lanes, input int times);
    pattern_valid = 1'b1;
    pattern_out   = lanes;
    repeat (times) tick();
    pattern_valid = 1'b0;
    pattern_out   = 8'h00;
  endtask

  initial begin
    resetn        = 1'b0;
    game_active   = 1'b1;
    clear         = 1'b0;
    pattern_valid = 1'b0;
    pattern_out   = 8'h00;
    player_a_keys = 4'h0;
    player_b_keys = 4'h0;

    // reset state
    repeat (3) tick();
    chk("reset_outputs", act_now(), 0);
    chk("reset_overflow", int'(overflow), 0);
    resetn = 1'b1;

    // perfect hit at now=103 (arrival 100, d=3)
    spawn(8'h01, 1);
    run_to(103);
    player_a_keys = 4'h1;
    tick();
    chk("perf_hit_a", int'(perfect_hit_a), 1);
    chk("perf_cnt_a", int'(perfect_cnt_a), 1);
    chk("perf_no_good", int'(good_hit_a), 0);
    tick();
    chk("perf_one_cycle", int'(perfect_hit_a), 0);
    player_a_keys = 4'h0;
    sum_miss_a = 0;
    run_to(130);
    chk("perf_lane_empty", sum_miss_a, 0);

    // early press ignored, later press good
    do_clear();
    spawn(8'h01, 1);
    run_to(80);
    player_a_keys = 4'h1;
    tick();
    chk("early_ignored", act_now(), 0);
    player_a_keys = 4'h0;
    tick();
    run_to(88);
    player_a_keys = 4'h1;
    tick();
    chk("good_hit_a", int'(good_hit_a), 1);
    chk("good_cnt_a", int'(good_cnt_a), 1);
    chk("good_not_perf", int'(perfect_hit_a), 0);
    player_a_keys = 4'h0;
    tick();
    chk("good_one_cycle", int'(good_hit_a), 0);

    // no press: miss appears only once now reaches 116
    do_clear();
    spawn(8'h01, 1);
    run_to(116);
    chk("miss_not_at_115", int'(miss_a), 0);
    sum_miss_a = 0;
    tick();
    chk("miss_a_at_116", int'(miss_a), 1);
    chk("miss_cnt_a", int'(miss_cnt_a), 1);
    tick();
    chk("miss_one_cycle", int'(miss_a), 0);
    run_to(200);
    chk("miss_total", sum_miss_a, 1);

    // window edges: d=-5 perfect, d=+15 good
    do_clear();
    spawn(8'h03, 1);
    run_to(95);
    player_a_keys = 4'h1;
    tick();
    chk("edge_perf_m5", int'(perfect_cnt_a), 1);
    run_to(115);
    player_a_keys = 4'h3;
    tick();
    chk("edge_good_p15", int'(good_cnt_a), 1);
    chk("edge_good_noperf", int'(perfect_cnt_a), 0);
    player_a_keys = 4'h0;

    // simultaneous lanes, player B
    do_clear();
    spawn(8'hF0, 1);
    run_to(100);
    player_b_keys = 4'hF;
    tick();
    chk("simul_cnt_b", int'(perfect_cnt_b), 4);
    chk("simul_hit_b", int'(perfect_hit_b), 1);
    chk("simul_a_quiet",
        int'(perfect_hit_a) + int'(good_hit_a) + int'(miss_a) +
        int'(perfect_cnt_a) + int'(good_cnt_a) + int'(miss_cnt_a), 0);
    tick();
    chk("simul_one_cycle", int'(perfect_hit_b), 0);
    player_b_keys = 4'h0;

    // overflow: fifth spawn on lane 1 is dropped, four misses follow
    do_clear();
    spawn(8'h02, 4);
    chk("ovf_not_at_4", int'(overflow), 0);
    spawn(8'h02, 1);
    chk("ovf_set", int'(overflow), 1);
    sum_miss_a = 0;
    sum_miss_b = 0;
    run_to(140);
    chk("ovf_misses", sum_miss_a, 4);
    chk("ovf_misses_b", sum_miss_b, 0);
    chk("ovf_sticky", int'(overflow), 1);
    do_clear();
    chk("ovf_cleared", int'(overflow), 0);
    spawn(8'h02, 4);
    do_clear();
    sum_miss_a = 0;
    run_to(140);
    chk("clear_empties", sum_miss_a, 0);

    // full lane accepts a push in the cycle its head expires
    do_clear();
    spawn(8'h01, 4);
    run_to(116);
    sum_miss_a = 0;
    spawn(8'h01, 1);
    chk("pushpop_miss", int'(miss_cnt_a), 1);
    chk("pushpop_no_ovf", int'(overflow), 0);
    run_to(240);
    chk("pushpop_total", sum_miss_a, 5);

    // pause from now=50 for 1000 cycles with key held across resume
    do_clear();
    spawn(8'h01, 1);
    run_to(50);
    game_active   = 1'b0;
    player_a_keys = 4'h1;
    sum_act = 0;
    repeat (1000) tick();
    game_active = 1'b1;
    run_to(100);
    chk("pause_silent", sum_act, 0);
    player_a_keys = 4'h0;
    tick();
    player_a_keys = 4'h1;
    tick();
    chk("pause_perf_at_100", int'(perfect_cnt_a), 1);
    player_a_keys = 4'h0;

    // key pressed during pause must not fire on resume
    do_clear();
    spawn(8'h01, 1);
    run_to(100);
    game_active = 1'b0;
    repeat (3) tick();
    player_a_keys = 4'h1;
    sum_act = 0;
    repeat (3) tick();
    game_active = 1'b1;
    repeat (2) tick();
    chk("resume_no_edge", sum_act, 0);
    player_a_keys = 4'h0;
    tick();
    player_a_keys = 4'h1;
    tick();
    chk("resume_fresh_perf", int'(perfect_cnt_a), 1);
    player_a_keys = 4'h0;

    // asynchronous reset with three arrows still queued
    do_clear();
    spawn(8'h0F, 1);
    run_to(100);
    player_a_keys = 4'h1;
    tick();
    chk("prerst_pulse", int'(perfect_hit_a), 1);
    resetn = 1'b0;
    #2;
    chk("rst_async_outs", act_now() + int'(overflow), 0);
    player_a_keys = 4'h0;
    repeat (2) tick();
    resetn = 1'b1;
    sum_miss_a = 0;
    sum_act    = 0;
    run_to(200);
    chk("rst_no_stale_miss", sum_miss_a, 0);
    chk("rst_no_activity", sum_act, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
